// File: rtl/eprisc_busmaster.sv
// epRISC host bus master: one 32-bit request word becomes one 6-edge byte-serial bus transaction.
// Define EPRISC_BUSMASTER_IRQ_EN to add the synchronised, sticky controller-interrupt flag.
module eprisc_busmaster #(
    parameter int unsigned CLKDIV = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReqValid,
    output logic        oReqReady,
    input  logic        iReqWrite,
    input  logic [14:0] iReqAddr,
    input  logic [15:0] iReqData,
    input  logic [1:0]  iReqTarget,
    output logic        oRspValid,
    output logic [31:0] oRspData,
    output logic        oBusClock,
    output logic [1:0]  oBusSelect,
    output logic [7:0]  oBusMOSI,
    input  logic [7:0]  iBusMISO,
    input  logic        iBusInterrupt,
    output logic        oIrqPending,
    input  logic        iIrqAck
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_t;

    state_t      state;
    logic [7:0]  divCnt;
    logic [3:0]  edgeCnt;
    logic [31:0] word;
    logic        expire;
    logic [2:0]  byteIdx;

    assign expire    = (divCnt == 8'(CLKDIV - 1));
    // Two bus-clock edges per byte slot: edgeCnt/2 selects the slot for both r_n and f_n.
    assign byteIdx   = edgeCnt[3:1];
    assign oReqReady = (state == StIdle);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state      <= StIdle;
            divCnt     <= '0;
            edgeCnt    <= '0;
            word       <= '0;
            oRspValid  <= 1'b0;
            oRspData   <= '0;
            oBusClock  <= 1'b0;
            oBusSelect <= '0;
            oBusMOSI   <= '0;
        end else begin
            oRspValid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (iReqValid) begin
                        word    <= {iReqWrite, iReqAddr, iReqData};
                        divCnt  <= '0;
                        edgeCnt <= '0;
                        if (iReqTarget == 2'd0) begin
                            oRspValid <= 1'b1;
                            oRspData  <= '0;
                            state     <= StDone;
                        end else begin
                            oBusSelect <= iReqTarget;
                            oBusClock  <= 1'b0;
                            oBusMOSI   <= '0;
                            state      <= StSetup;
                        end
                    end
                end
                StSetup: begin
                    if (expire) begin
                        divCnt <= '0;
                        state  <= StShift;
                    end else begin
                        divCnt <= divCnt + 8'd1;
                    end
                end
                StShift: begin
                    if (expire) begin
                        divCnt    <= '0;
                        oBusClock <= ~oBusClock;
                        edgeCnt   <= edgeCnt + 4'd1;
                        if (!oBusClock) begin
                            case (byteIdx)
                                3'd0:    oBusMOSI <= word[7:0];
                                3'd1:    oBusMOSI <= word[15:8];
                                3'd2:    oBusMOSI <= word[23:16];
                                3'd3:    oBusMOSI <= word[31:24];
                                default: oBusMOSI <= 8'h00;
                            endcase
                        end else begin
                            if (byteIdx < 3'd4) begin
                                oRspData[{byteIdx[1:0], 3'b000} +: 8] <= iBusMISO;
                            end
                            if (edgeCnt == 4'd11) begin
                                oRspValid  <= 1'b1;
                                oBusSelect <= '0;
                                oBusMOSI   <= '0;
                                state      <= StDone;
                            end
                        end
                    end else begin
                        divCnt <= divCnt + 8'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef EPRISC_BUSMASTER_IRQ_EN
    logic [1:0] irqSync;
    logic       irqPrev;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            irqSync     <= '0;
            irqPrev     <= 1'b0;
            oIrqPending <= 1'b0;
        end else begin
            irqSync <= {irqSync[0], iBusInterrupt};
            irqPrev <= irqSync[1];
            // A fresh edge outranks a coincident acknowledge so no interrupt is lost.
            if (irqSync[1] && !irqPrev) begin
                oIrqPending <= 1'b1;
            end else if (iIrqAck) begin
                oIrqPending <= 1'b0;
            end
        end
    end
`else
    logic unusedIrq;
    assign unusedIrq   = iBusInterrupt ^ iIrqAck;
    assign oIrqPending = 1'b0;
`endif

endmodule

// File: tb/tb_eprisc_busmaster.sv
// Randomised bench for eprisc_busmaster: a bench-side controller feeds MISO and a transaction-level
// model predicts MOSI bytes, latency and the returned word.
module tb_eprisc_busmaster;

    localparam int unsigned CLKDIV = 2;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iReqValid = 1'b0;
    logic        oReqReady;
    logic        iReqWrite = 1'b0;
    logic [14:0] iReqAddr = '0;
    logic [15:0] iReqData = '0;
    logic [1:0]  iReqTarget = '0;
    logic        oRspValid;
    logic [31:0] oRspData;
    logic        oBusClock;
    logic [1:0]  oBusSelect;
    logic [7:0]  oBusMOSI;
    logic [7:0]  iBusMISO = '0;
    logic        iBusInterrupt = 1'b0;
    logic        oIrqPending;
    logic        iIrqAck = 1'b0;

    int checkCount = 0;
    int errorCount = 0;
    int rspCount = 0;

    eprisc_busmaster #(.CLKDIV(CLKDIV)) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iReqValid    (iReqValid),
        .oReqReady    (oReqReady),
        .iReqWrite    (iReqWrite),
        .iReqAddr     (iReqAddr),
        .iReqData     (iReqData),
        .iReqTarget   (iReqTarget),
        .oRspValid    (oRspValid),
        .oRspData     (oRspData),
        .oBusClock    (oBusClock),
        .oBusSelect   (oBusSelect),
        .oBusMOSI     (oBusMOSI),
        .iBusMISO     (iBusMISO),
        .iBusInterrupt(iBusInterrupt),
        .oIrqPending  (oIrqPending),
        .iIrqAck      (iIrqAck)
    );

    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [14:0] a, input logic [15:0] d,
                         input logic [1:0] t, output logic [31:0] word);
        int waitCyc;
        waitCyc = 0;
        while (!oReqReady && waitCyc < 100) begin
            tick();
            waitCyc++;
        end
        checkVal("readyBeforeAccept", oReqReady, 1);
        iReqValid  = 1'b1;
        iReqWrite  = w;
        iReqAddr   = a;
        iReqData   = d;
        iReqTarget = t;
        word       = {w, a, d};
        tick();
    endtask

    // Called just after the accept edge; plays the controller and checks the whole transaction.
    task automatic watchTxn(input logic [31:0] w, input logic [1:0] target,
                            input logic [47:0] misoPlan, input int abortRise,
                            output logic aborted);
        logic [7:0] mosiSeen [6];
        int   cyc;
        int   rises;
        int   stray;
        int   selBad;
        logic prevClk;
        logic prevSelZero;
        logic done;
        aborted = 1'b0;
        cyc = 0;
        rises = 0;
        stray = 0;
        selBad = 0;
        done = 1'b0;
        for (int k = 0; k < 6; k++) mosiSeen[k] = 8'h00;
        checkVal("setupSelect", oBusSelect, target);
        checkVal("setupClock", oBusClock, 0);
        prevClk = oBusClock;
        prevSelZero = (oBusSelect == 2'd0);
        while (!done && cyc < 16 * CLKDIV + 4) begin
            tick();
            cyc++;
            if (oBusClock && !prevClk) begin
                if (rises < 6) begin
                    mosiSeen[rises] = oBusMOSI;
                    iBusMISO = misoPlan[8*rises +: 8];
                end
                if (oBusSelect != target) selBad++;
                rises++;
            end
            if (oBusClock != prevClk && oBusSelect == 2'd0 && prevSelZero) stray++;
            prevClk = oBusClock;
            prevSelZero = (oBusSelect == 2'd0);
            if (abortRise > 0 && rises == abortRise) begin
                aborted = 1'b1;
                return;
            end
            if (oRspValid) done = 1'b1;
        end
        if (done) rspCount++;
        checkVal("rspSeen", done, 1);
        checkVal("latency", cyc, 13 * CLKDIV);
        checkVal("risingEdges", rises, 6);
        checkVal("selectDuringShift", selBad, 0);
        checkVal("clockWhileDeselected", stray, 0);
        for (int k = 0; k < 5; k++) begin
            checkVal($sformatf("mosi_r%0d", k + 1), mosiSeen[k], (k < 4) ? w[8*k +: 8] : 8'h00);
        end
        checkVal("rspData", oRspData, misoPlan[31:0]);
        checkVal("doneSelect", oBusSelect, 0);
        checkVal("doneMosi", oBusMOSI, 0);
        checkVal("doneClock", oBusClock, 0);
        tick();
        checkVal("rspPulseWidth", oRspValid, 0);
        checkVal("readyAfterDone", oReqReady, 1);
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] word2;
        logic [47:0] plan;
        logic [47:0] plan2;
        logic        aborted;
        int          rspBefore;
        logic        seen;

        #3;
        checkVal("rstReady", oReqReady, 1);
        checkVal("rstClock", oBusClock, 0);
        checkVal("rstSelect", oBusSelect, 0);
        checkVal("rstMosi", oBusMOSI, 0);
        checkVal("rstRspValid", oRspValid, 0);
        checkVal("rstRspData", oRspData, 0);
        checkVal("rstIrq", oIrqPending, 0);
        tick();
        iRst = 1'b1;
        tick();

        // Directed write: bytes EF, BE, 34, 81, 00.
        plan = {$urandom, $urandom};
        issue(1'b1, 15'h0134, 16'hBEEF, 2'd1, word);
        iReqValid = 1'b0;
        checkVal("writeWord", word, 32'h8134BEEF);
        watchTxn(word, 2'd1, plan, 0, aborted);

        // Directed read capture: MISO 11,22,33,44 returns 0x44332211.
        issue(1'b0, 15'h0134, 16'h0000, 2'd2, word);
        iReqValid = 1'b0;
        watchTxn(word, 2'd2, 48'h6655_44332211, 0, aborted);

        // Target 0: no bus activity, immediate zero response.
        issue(1'b1, 15'h7FFF, 16'hFFFF, 2'd0, word);
        iReqValid = 1'b0;
        checkVal("t0RspValid", oRspValid, 1);
        checkVal("t0RspData", oRspData, 0);
        checkVal("t0Select", oBusSelect, 0);
        checkVal("t0Clock", oBusClock, 0);
        tick();
        checkVal("t0PulseWidth", oRspValid, 0);
        checkVal("t0ClockAfter", oBusClock, 0);
        checkVal("t0Ready", oReqReady, 1);

        // Back-to-back: iReqValid held high across two requests.
        rspBefore = rspCount;
        plan  = {$urandom, $urandom};
        plan2 = {$urandom, $urandom};
        issue(1'b1, 15'h1234, 16'hA5A5, 2'd3, word);
        iReqWrite  = 1'b0;
        iReqAddr   = 15'h4321;
        iReqData   = 16'h5A5A;
        iReqTarget = 2'd1;
        word2      = {1'b0, 15'h4321, 16'h5A5A};
        watchTxn(word, 2'd3, plan, 0, aborted);
        checkVal("b2bGapSelect", oBusSelect, 0);
        checkVal("b2bGapClock", oBusClock, 0);
        tick();
        iReqValid = 1'b0;
        watchTxn(word2, 2'd1, plan2, 0, aborted);
        checkVal("b2bPulses", rspCount - rspBefore, 2);

        // Randomised traffic.
        for (int n = 0; n < 8; n++) begin
            logic [1:0] t;
            t = 2'($urandom_range(1, 3));
            plan = {$urandom, $urandom};
            issue(1'($urandom), 15'($urandom), 16'($urandom), t, word);
            iReqValid = 1'b0;
            watchTxn(word, t, plan, 0, aborted);
        end

        // Reset mid-transaction, after r3.
        plan = {$urandom, $urandom};
        issue(1'b1, 15'h0055, 16'h1357, 2'd2, word);
        iReqValid = 1'b0;
        watchTxn(word, 2'd2, plan, 3, aborted);
        checkVal("abortReached", aborted, 1);
        #2;
        iRst = 1'b0;
        #1;
        checkVal("midRstClock", oBusClock, 0);
        checkVal("midRstSelect", oBusSelect, 0);
        checkVal("midRstMosi", oBusMOSI, 0);
        checkVal("midRstRspValid", oRspValid, 0);
        checkVal("midRstRspData", oRspData, 0);
        checkVal("midRstReady", oReqReady, 1);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (oRspValid) seen = 1'b1;
        end
        checkVal("midRstNoRsp", seen, 0);
        iRst = 1'b1;
        tick();
        plan = {$urandom, $urandom};
        issue(1'b0, 15'h2AAA, 16'hC3C3, 2'd3, word);
        iReqValid = 1'b0;
        watchTxn(word, 2'd3, plan, 0, aborted);

`ifdef EPRISC_BUSMASTER_IRQ_EN
        checkVal("irqIdle", oIrqPending, 0);
        iBusInterrupt = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (oIrqPending) seen = 1'b1;
        end
        checkVal("irqSet", seen, 1);
        iBusInterrupt = 1'b0;
        repeat (4) tick();
        checkVal("irqSticky", oIrqPending, 1);
        iIrqAck = 1'b1;
        tick();
        iIrqAck = 1'b0;
        checkVal("irqAck", oIrqPending, 0);
        iBusInterrupt = 1'b1;
        iIrqAck = 1'b1;
        repeat (3) tick();
        iIrqAck = 1'b0;
        tick();
        checkVal("irqSetWins", oIrqPending, 1);
`else
        iBusInterrupt = 1'b1;
        repeat (5) tick();
        iBusInterrupt = 1'b0;
        checkVal("irqDisabled", oIrqPending, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
